audio_sample_sequencer: RTL and testbench

AUDIO_SAMPLE_SEQUENCER -- requirements
Module: audio_sample_sequencer

---
 rtl/audio_sample_sequencer.sv | 159 +++++++++++++++
 tb/tb_audio_sample_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_sequencer.sv
// Audio sample sequencer: every DIV fast_clock cycles it pulls one sample from the
// codec ADC, passes it through an external processing stage (or loops it straight
// back when bypass is set) and pushes the result to the codec DAC.
//
// Ports:
//   fast_clock, reset            sole clock, synchronous active-high reset
//   read_ready/readdata          ADC sample available / 24-bit ADC sample
//   read_enable                  one-cycle pulse consuming the ADC sample
//   write_ready/writedata        DAC can accept / 24-bit sample to DAC (registered)
//   write_enable                 one-cycle pulse committing writedata
//   bypass                       loop captured sample to DAC (sampled in READ only)
//   sample_out/sample_valid      N-bit quantized sample offered to processing
//   proc_data/proc_valid         processed result and its handshake
//   busy                         FSM is not idle
//   overrun_count                saturating count of dropped sample ticks
module audio_sample_sequencer #(
  parameter int unsigned N   = 8,
  parameter int unsigned DIV = 1042
) (
  input  logic          fast_clock,
  input  logic          reset,
  input  logic          read_ready,
  input  logic [23:0]   readdata,
  output logic          read_enable,
  input  logic          write_ready,
  output logic [23:0]   writedata,
  output logic          write_enable,
  input  logic          bypass,
  output logic [N-1:0]  sample_out,
  output logic          sample_valid,
  input  logic [N-1:0]  proc_data,
  input  logic          proc_valid,
  output logic          busy,
  output logic [7:0]    overrun_count
);

  localparam int unsigned CntW = $clog2(DIV);

  typedef enum logic [2:0] {
    StIdle,
    StWaitRd,
    StRead,
    StProc,
    StWaitWr,
    StWrite
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        ovr_q, ovr_d;
  logic [N-1:0]      sample_q, sample_d;
  logic [N-1:0]      result_q, result_d;
  logic [23:0]       writedata_q, writedata_d;
  logic [23:0]       wr_word;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              tick;

  // Free-running sample-period counter; it never stalls, so ticks stay periodic
  // even while a transaction is held up.
  assign tick  = (cnt_q == CntW'(DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CntW'(1);

    // Overrun: any tick not seen in IDLE is lost.
    ovr_d = ovr_q;
    if (tick && (state_q != StIdle) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end

    wr_word            = '0;
    wr_word[23 -: N]   = result_q;

    state_d     = state_q;
    sample_d    = sample_q;
    result_d    = result_q;
    writedata_d = writedata_q;

    unique case (state_q)
      StIdle: begin
        if (tick) state_d = StWaitRd;
      end
      StWaitRd: begin
        if (read_ready) state_d = StRead;
      end
      StRead: begin
        sample_d = readdata[23 -: N];
        if (bypass) begin
          result_d = readdata[23 -: N];
          state_d  = StWaitWr;
        end else begin
          state_d  = StProc;
        end
      end
      StProc: begin
        if (proc_valid) begin
          result_d = proc_data;
          state_d  = StWaitWr;
        end
      end
      StWaitWr: begin
        if (write_ready) begin
          writedata_d = wr_word;
          state_d     = StWrite;
        end
      end
      StWrite: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state.
    rd_en_d = (state_d == StRead);
    wr_en_d = (state_d == StWrite);
    valid_d = (state_d == StProc);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge fast_clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ovr_q       <= '0;
      sample_q    <= '0;
      result_q    <= '0;
      writedata_q <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ovr_q       <= ovr_d;
      sample_q    <= sample_d;
      result_q    <= result_d;
      writedata_q <= writedata_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign read_enable   = rd_en_q;
  assign write_enable  = wr_en_q;
  assign writedata     = writedata_q;
  assign sample_out    = sample_q;
  assign sample_valid  = valid_q;
  assign busy          = busy_q;
  assign overrun_count = ovr_q;

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Scoreboard bench for audio_sample_sequencer (N=8, DIV=8). Stimulus pushes the
// expected read/write/sample events with hand-computed cycle numbers; a monitor
// pops and compares whenever the DUT pulses read_enable/write_enable or raises
// sample_valid.
module tb_audio_sample_sequencer;

  logic        clk;
  logic        reset;
  logic        read_ready;
  logic [23:0] readdata;
  logic        read_enable;
  logic        write_ready;
  logic [23:0] writedata;
  logic        write_enable;
  logic        bypass;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic [7:0]  proc_data;
  logic        proc_valid;
  logic        busy;
  logic [7:0]  overrun_count;

  audio_sample_sequencer #(
    .N   (8),
    .DIV (8)
  ) dut (
    .fast_clock    (clk),
    .reset         (reset),
    .read_ready    (read_ready),
    .readdata      (readdata),
    .read_enable   (read_enable),
    .write_ready   (write_ready),
    .writedata     (writedata),
    .write_enable  (write_enable),
    .bypass        (bypass),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .proc_data     (proc_data),
    .proc_valid    (proc_valid),
    .busy          (busy),
    .overrun_count (overrun_count)
  );

  typedef struct {
    int          cyc;
    logic [23:0] data;
  } ev_t;

  int   rd_q[$];
  ev_t  wr_q[$];
  ev_t  sv_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   armed   = 0;
  logic prev_sv = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (armed) begin
      if (read_enable || write_enable) begin
        check("rd_wr_exclusive", 32'(read_enable && write_enable), 32'd0);
      end
      if (read_enable === 1'b1) begin
        if (rd_q.size() == 0) begin
          check("unexpected_read", 32'(read_enable), 32'd0);
        end else begin
          check("read_cycle", 32'(cyc), 32'(rd_q.pop_front()));
        end
      end
      if (write_enable === 1'b1) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 32'(write_enable), 32'd0);
        end else begin
          ev_t e;
          e = wr_q.pop_front();
          check("write_cycle", 32'(cyc), 32'(e.cyc));
          check("writedata", 32'(writedata), 32'(e.data));
        end
      end
      if (sample_valid === 1'b1 && prev_sv === 1'b0) begin
        if (sv_q.size() == 0) begin
          check("unexpected_sample_valid", 32'(sample_valid), 32'd0);
        end else begin
          ev_t e;
          e = sv_q.pop_front();
          check("sample_valid_cycle", 32'(cyc), 32'(e.cyc));
          check("sample_out", 32'(sample_out), 32'(e.data));
        end
      end
      prev_sv = sample_valid;
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Returns the cycle index of the reset edge (counter is 0 in that cycle).
  task automatic do_reset(output int r);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    r = cyc;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_read_enable"}, 32'(read_enable), 32'd0);
    check({tag, "_write_enable"}, 32'(write_enable), 32'd0);
    check({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_overrun"}, 32'(overrun_count), 32'd0);
    check({tag, "_writedata"}, 32'(writedata), 32'd0);
    check({tag, "_sample_out"}, 32'(sample_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int c0;
    reset       = 1'b0;
    read_ready  = 1'b1;
    write_ready = 1'b1;
    bypass      = 1'b1;
    readdata    = 24'hA5C3F0;
    proc_data   = 8'h00;
    proc_valid  = 1'b0;

    // Bypass loop, repeating every 8 cycles.
    do_reset(r);
    armed = 1;
    check_zero_outputs("reset1");
    for (int k = 0; k < 3; k++) begin
      rd_q.push_back(r + 9 + 8 * k);
      wr_q.push_back('{cyc: r + 11 + 8 * k, data: 24'hA50000});
    end
    wait_until(r + 7);
    check("busy_before_tick", 32'(busy), 32'd0);
    wait_until(r + 8);
    check("busy_after_tick", 32'(busy), 32'd1);
    wait_until(r + 28);
    read_ready = 1'b0;
    check("bypass_overrun", 32'(overrun_count), 32'd0);

    // Processing path, bypass changes outside READ ignored, tick in WRITE dropped.
    do_reset(r);
    bypass     = 1'b0;
    readdata   = 24'h7F0000;
    read_ready = 1'b1;
    rd_q.push_back(r + 9);
    sv_q.push_back('{cyc: r + 10, data: 24'h00007F});
    wr_q.push_back('{cyc: r + 15, data: 24'h120000});
    wait_until(r + 8);
    proc_valid = 1'b1;
    proc_data  = 8'hEE;
    wait_until(r + 9);
    proc_valid = 1'b0;
    wait_until(r + 11);
    bypass = 1'b1;
    wait_until(r + 13);
    check("sample_out_in_proc", 32'(sample_out), 32'h7F);
    proc_valid = 1'b1;
    proc_data  = 8'h12;
    wait_until(r + 14);
    proc_valid = 1'b0;
    read_ready = 1'b0;
    check("sample_valid_after_hs", 32'(sample_valid), 32'd0);
    wait_until(r + 16);
    check("overrun_tick_in_write", 32'(overrun_count), 32'd1);
    check("busy_idle_after_write", 32'(busy), 32'd0);
    check("sample_out_holds", 32'(sample_out), 32'h7F);

    // Processing withheld across two ticks.
    do_reset(r);
    bypass     = 1'b0;
    readdata   = 24'h3C0000;
    read_ready = 1'b1;
    rd_q.push_back(r + 9);
    sv_q.push_back('{cyc: r + 10, data: 24'h00003C});
    wr_q.push_back('{cyc: r + 29, data: 24'h5A0000});
    rd_q.push_back(r + 33);
    sv_q.push_back('{cyc: r + 34, data: 24'h00003C});
    wr_q.push_back('{cyc: r + 36, data: 24'h810000});
    wait_until(r + 20);
    check("overrun_one_tick", 32'(overrun_count), 32'd1);
    wait_until(r + 27);
    check("overrun_two_ticks", 32'(overrun_count), 32'd2);
    proc_valid = 1'b1;
    proc_data  = 8'h5A;
    wait_until(r + 28);
    proc_valid = 1'b0;
    wait_until(r + 30);
    check("overrun_after_hs", 32'(overrun_count), 32'd2);
    check("busy_after_withheld", 32'(busy), 32'd0);
    wait_until(r + 34);
    proc_valid = 1'b1;
    proc_data  = 8'h81;
    wait_until(r + 35);
    proc_valid = 1'b0;
    wait_until(r + 36);
    read_ready = 1'b0;
    wait_until(r + 38);
    check("overrun_resumed", 32'(overrun_count), 32'd2);

    // Overrun saturation with DAC stalled.
    do_reset(r);
    bypass      = 1'b1;
    readdata    = 24'hA5C3F0;
    read_ready  = 1'b1;
    write_ready = 1'b0;
    rd_q.push_back(r + 9);
    wr_q.push_back('{cyc: r + 2501, data: 24'hA50000});
    wait_until(r + 1004);
    check("overrun_partial", 32'(overrun_count), 32'd124);
    check("busy_stalled", 32'(busy), 32'd1);
    wait_until(r + 2500);
    check("overrun_saturated", 32'(overrun_count), 32'd255);
    write_ready = 1'b1;
    wait_until(r + 2501);
    read_ready = 1'b0;
    wait_until(r + 2510);
    check("overrun_stays_255", 32'(overrun_count), 32'd255);

    // Reset while waiting to write abandons the sample.
    c0          = r + 2510;
    read_ready  = 1'b1;
    write_ready = 1'b0;
    rd_q.push_back(c0 + 1);
    wait_until(c0 + 3);
    reset = 1'b1;
    wait_until(c0 + 4);
    reset       = 1'b0;
    write_ready = 1'b1;
    r           = c0 + 4;
    check_zero_outputs("midreset");
    rd_q.push_back(r + 9);
    wr_q.push_back('{cyc: r + 11, data: 24'hA50000});
    wait_until(r + 12);
    read_ready = 1'b0;
    wait_until(r + 20);
    check("overrun_after_midreset", 32'(overrun_count), 32'd0);

    check("read_queue_drained", 32'(rd_q.size()), 32'd0);
    check("write_queue_drained", 32'(wr_q.size()), 32'd0);
    check("sample_queue_drained", 32'(sv_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
